ifetch: RTL and testbench
=========================

Name: ifetch

Overview:
- Instruction fetch unit: the requesting side of the instruction memory's synchronous-read port.
- Owns the program counter and drives one word address per cycle into the instruction memory. Instruction memory returns the word one clock later.
- Pairs each returned word with its PC and hands it to decode through a valid/ready handshake.
- Absorbs decode back-pressure without dropping or duplicating words. Accepts control-flow redirects from execute.

Parameters:
- XLEN, 32, datapath and address width in bits.
- RESET_PC, 0, first fetch address after reset; must be 4-byte aligned.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_addr  out  XLEN  byte address presented to instruction memory this cycle (combinational).
- imem_rdata  in  XLEN  word read from instruction memory, valid the cycle after its address was presented.
- redirect_valid  in  1  redirect fetch to redirect_pc this cycle.
- redirect_pc  in  XLEN  redirect target byte address; bits [1:0] ignored (treated as 0).
- inst_valid  out  1  inst/inst_pc hold a fetched instruction.
- inst_ready  in  1  decode accepts the instruction this cycle.
- inst  out  XLEN  instruction word.
- inst_pc  out  XLEN  byte address of inst.

Behaviour:
- State:
  - fetch_pc: next address to issue.
  - pend_valid/pend_pc: a read was issued last cycle, so imem_rdata holds it now.
  - hold_valid/hold_inst/hold_pc: one-entry skid register.
- Reset (async, rst_n=0):
  - fetch_pc=RESET_PC; pend_valid=0; hold_valid=0; hold_inst=0; hold_pc=0.
  - inst_valid=0; imem_addr=RESET_PC.
  - Reset mid-operation discards all in-flight and held words.
- Output select:
  - hold_valid=1: inst=hold_inst, inst_pc=hold_pc.
  - Otherwise: inst=imem_rdata, inst_pc=pend_pc.
  - inst_valid = (hold_valid | pend_valid) & ~redirect_valid.
  - fire = inst_valid & inst_ready.
- stall = hold_valid & pend_valid & ~inst_ready & ~redirect_valid.
- Redirect has priority:
  - imem_addr = {redirect_pc[XLEN-1:2],2'b00}.
  - Next cycle: pend_valid=1, pend_pc=that address, fetch_pc=that address+4, hold_valid=0.
  - Any word visible this cycle is discarded; fire is impossible because inst_valid=0.
- Stall (capacity full, decode not ready):
  - imem_addr=pend_pc, so memory re-reads the same word.
  - fetch_pc, pend and hold are unchanged.
- Otherwise, issue:
  - imem_addr=fetch_pc; fetch_pc<=fetch_pc+4; pend_valid<=1, pend_pc<=fetch_pc.
- Skid update when not redirect and not stall:
  - hold_valid & fire & pend_valid: hold <= {imem_rdata, pend_pc}.
  - hold_valid & fire & ~pend_valid: hold_valid<=0.
  - ~hold_valid & pend_valid & ~fire: hold <= {imem_rdata, pend_pc}.
  - Otherwise: hold unchanged.
- Latency and throughput:
  - First instruction is valid on the cycle after the address is issued.
  - Steady state: one instruction per cycle while inst_ready=1.
  - Max in-flight = 2 (hold + pend).
- Ordering: inst_pc strictly increases by 4 between consecutive fires unless a redirect intervenes. No word is lost or emitted twice.
- Arithmetic: fetch_pc+4 wraps modulo 2^XLEN (0xFFFFFFFC -> 0x00000000 at XLEN=32).
- Input stability: inst_valid/inst/inst_pc stay stable while inst_valid=1 and inst_ready=0, except on redirect.

Test Plan:
- Reset release, inst_ready=1, memory word n = 0x1000_0000+n -> inst_valid rises 1 cycle after rst_n high. Fires (inst_pc, inst): (0x0, 0x10000000), (0x4, 0x10000001), (0x8, 0x10000002) on consecutive cycles.
- inst_ready=0 for 5 cycles after first valid, then 1 -> inst/inst_pc frozen at 0x0 during the stall. imem_addr settles at 0x4 (re-read). After release, fires are 0x0, 0x4, 0x8 with no gaps or duplicates.
- Alternating inst_ready 1/0 for 20 cycles -> accepted PC sequence is 0x0, 0x4, 0x8, … with no skips. inst is stable on every held cycle.
- redirect_valid with redirect_pc=0x203 while hold and pend are both full -> inst_valid=0 that cycle; imem_addr=0x200. Next cycle inst_pc=0x200, then 0x204. No older word ever fires.
- RESET_PC=0xFFFFFFF8, XLEN=32, inst_ready=1 -> fires at inst_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
- rst_n asserted asynchronously mid-stall with hold full -> inst_valid=0 immediately, before the next clock edge. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch unit with one-entry skid register
// Drives the instruction memory's sync-read port and pairs each word with its PC.
module ifetch #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            pend_valid_q, pend_valid_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    logic            hold_valid_q, hold_valid_d;
    logic [XLEN-1:0] hold_inst_q, hold_inst_d;
    logic [XLEN-1:0] hold_pc_q, hold_pc_d;

    logic [XLEN-1:0] redirect_addr;
    logic            fire;
    logic            stall;

    assign redirect_addr = {redirect_pc[XLEN-1:2], 2'b00};
    assign inst_valid    = (hold_valid_q | pend_valid_q) & ~redirect_valid;
    assign fire          = inst_valid & inst_ready;
    assign stall         = hold_valid_q & pend_valid_q & ~inst_ready & ~redirect_valid;
    assign inst          = hold_valid_q ? hold_inst_q : imem_rdata;
    assign inst_pc       = hold_valid_q ? hold_pc_q : pend_pc_q;

    always_comb begin
        fetch_pc_d   = fetch_pc_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        hold_valid_d = hold_valid_q;
        hold_inst_d  = hold_inst_q;
        hold_pc_d    = hold_pc_q;
        imem_addr    = fetch_pc_q;

        if (redirect_valid) begin
            imem_addr    = redirect_addr;
            pend_valid_d = 1'b1;
            pend_pc_d    = redirect_addr;
            fetch_pc_d   = redirect_addr + PC_STEP;
            hold_valid_d = 1'b0;
        end else if (stall) begin
            // Both slots full: re-read the pending word so imem_rdata still holds it next cycle.
            imem_addr = pend_pc_q;
        end else begin
            fetch_pc_d   = fetch_pc_q + PC_STEP;
            pend_valid_d = 1'b1;
            pend_pc_d    = fetch_pc_q;
            if (pend_valid_q && (hold_valid_q ? fire : !fire)) begin
                hold_valid_d = 1'b1;
                hold_inst_d  = imem_rdata;
                hold_pc_d    = pend_pc_q;
            end else if (hold_valid_q && fire) begin
                hold_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q   <= RESET_PC;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= '0;
            hold_valid_q <= 1'b0;
            hold_inst_q  <= '0;
            hold_pc_q    <= '0;
        end else begin
            fetch_pc_q   <= fetch_pc_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            hold_valid_q <= hold_valid_d;
            hold_inst_q  <= hold_inst_d;
            hold_pc_q    <= hold_pc_d;
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - self-checking bench for ifetch
// Stream model (expected next PC, memory word formula) plus directed literal checks.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        inst_ready = 1'b1;

    logic [31:0] addr_a, rdata_a, inst_a, pc_a;
    logic        valid_a;
    logic [31:0] addr_b, rdata_b, inst_b, pc_b;
    logic        valid_b;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_pc = 32'h0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_inst = 32'h0;
    logic [31:0] prev_pc = 32'h0;
    logic [31:0] fired[$];

    always #5 clk = ~clk;

    ifetch #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n), .imem_addr(addr_a), .imem_rdata(rdata_a),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(valid_a), .inst_ready(inst_ready), .inst(inst_a), .inst_pc(pc_a)
    );

    ifetch #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .imem_addr(addr_b), .imem_rdata(rdata_b),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(valid_b), .inst_ready(inst_ready), .inst(inst_b), .inst_pc(pc_b)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    always @(posedge clk) begin
        rdata_a <= mem_word(addr_a);
        rdata_b <= mem_word(addr_b);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Stream model: accepted words must follow exp_pc in steps of 4, restarting at a redirect target.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_pc    = 32'h0;
            prev_hold = 1'b0;
            fired.delete();
        end else begin
            if (redirect_valid) begin
                chk_b("model_redirect_blank", valid_a, 1'b0);
            end else if (prev_hold) begin
                chk_b("model_hold_valid", valid_a, 1'b1);
                chk("model_hold_inst", inst_a, prev_inst);
                chk("model_hold_pc", pc_a, prev_pc);
            end
            if (valid_a && inst_ready) begin
                chk("model_fire_pc", pc_a, exp_pc);
                chk("model_fire_inst", inst_a, mem_word(exp_pc));
                fired.push_back(pc_a);
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect_valid) exp_pc = redirect_pc & ~32'h3;
            prev_hold = valid_a & ~inst_ready & ~redirect_valid;
            prev_inst = inst_a;
            prev_pc   = pc_a;
        end
    end

    task automatic do_reset(input logic rdy);
        @(posedge clk); #1;
        rst_n = 1'b0;
        inst_ready = rdy;
        redirect_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic expect_word(input string name, input logic [31:0] pc, input logic [31:0] word);
        chk_b({name, "_valid"}, valid_a, 1'b1);
        chk({name, "_pc"}, pc_a, pc);
        chk({name, "_inst"}, inst_a, word);
    endtask

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk_b("reset_valid", valid_a, 1'b0);
        chk("reset_addr", addr_a, 32'h0);
        chk("reset_addr_wrap", addr_b, 32'hFFFF_FFF8);

        // streaming from reset, plus the wrapping instance
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk_b("c0_valid", valid_a, 1'b0);
        chk("c0_addr", addr_a, 32'h0);
        @(negedge clk);
        expect_word("stream0", 32'h0, 32'h1000_0000);
        chk("wrap0_pc", pc_b, 32'hFFFF_FFF8);
        chk("wrap0_inst", inst_b, 32'h4FFF_FFFE);
        @(negedge clk);
        expect_word("stream1", 32'h4, 32'h1000_0001);
        chk("wrap1_pc", pc_b, 32'hFFFF_FFFC);
        chk("wrap1_inst", inst_b, 32'h4FFF_FFFF);
        @(negedge clk);
        expect_word("stream2", 32'h8, 32'h1000_0002);
        chk_b("wrap2_valid", valid_b, 1'b1);
        chk("wrap2_pc", pc_b, 32'h0);
        chk("wrap2_inst", inst_b, 32'h1000_0000);
        @(posedge clk); #1;
        chk("stream_count", 32'(fired.size()), 32'd3);

        // five-cycle stall right after the first valid word
        do_reset(1'b0);
        @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            expect_word("stall", 32'h0, 32'h1000_0000);
            chk("stall_addr", addr_a, 32'h4);
        end
        @(posedge clk); #1 inst_ready = 1'b1;
        @(negedge clk);
        expect_word("unstall0", 32'h0, 32'h1000_0000);
        @(negedge clk);
        expect_word("unstall1", 32'h4, 32'h1000_0001);
        @(negedge clk);
        expect_word("unstall2", 32'h8, 32'h1000_0002);
        @(posedge clk); #1;
        chk("unstall_count", 32'(fired.size()), 32'd3);

        // alternating ready
        do_reset(1'b1);
        for (int k = 0; k < 20; k++) begin
            inst_ready = (k % 2 == 0);
            @(negedge clk);
            @(posedge clk); #1;
        end
        chk("alt_count", 32'(fired.size()), 32'd9);
        chk("alt_first", fired[0], 32'h0);
        chk("alt_last", fired[8], 32'h20);

        // redirect with hold and pend both full
        do_reset(1'b0);
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h203;
        @(negedge clk);
        chk_b("redir_valid", valid_a, 1'b0);
        chk("redir_addr", addr_a, 32'h200);
        @(posedge clk); #1;
        redirect_valid = 1'b0;
        inst_ready = 1'b1;
        chk("redir_no_old_fire", 32'(fired.size()), 32'd0);
        @(negedge clk);
        expect_word("redir0", 32'h200, 32'h1000_0080);
        @(negedge clk);
        expect_word("redir1", 32'h204, 32'h1000_0081);
        @(posedge clk); #1;
        chk("redir_count", 32'(fired.size()), 32'd2);
        chk("redir_first", fired[0], 32'h200);

        // asynchronous reset mid-stall with hold full
        do_reset(1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk_b("pre_areset_valid", valid_a, 1'b1);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk_b("areset_valid", valid_a, 1'b0);
        chk("areset_addr", addr_a, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        inst_ready = 1'b1;
        @(negedge clk);
        chk_b("restart_c0_valid", valid_a, 1'b0);
        @(negedge clk);
        expect_word("restart0", 32'h0, 32'h1000_0000);
        @(negedge clk);
        expect_word("restart1", 32'h4, 32'h1000_0001);

        @(posedge clk); #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
